// File: rtl/ad978x_dac_ctrl.sv
// AD978x DAC controller: SPI register master with read-back, timed DAC hardware reset,
// and an N-channel sample multiplexer with a channel-0 frame marker (DCI).
module ad978x_dac_ctrl #(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned DAC_W      = 16,
    parameter int unsigned SCK_DIV    = 4,
    parameter int unsigned RST_CYCLES = 64,
    parameter int unsigned OFFSET_BIN = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  cmd_trig_in,
    input  logic                  cmd_rw_in,
    input  logic [4:0]            cmd_addr_in,
    input  logic [7:0]            cmd_data_in,
    output logic [7:0]            cmd_data_out,
    output logic                  cmd_busy_out,
    output logic                  cmd_done_out,
    output logic                  rst_out,
    output logic                  spi_scs_out,
    output logic                  spi_sck_out,
    output logic                  spi_sdo_out,
    input  logic                  spi_sdi_in,
    input  logic [N_CH*DAC_W-1:0] dac_in,
    input  logic                  dac_valid_in,
    output logic [DAC_W-1:0]      d_out,
    output logic                  dci_out
);

    localparam int unsigned DivW = $clog2(SCK_DIV + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(SCK_DIV - 1);
    localparam int unsigned RstW = $clog2(RST_CYCLES + 1);
    localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);
    localparam int unsigned ChW = $clog2(N_CH);
    localparam logic [ChW-1:0] ChLast = ChW'(N_CH - 1);
    localparam logic [DAC_W-1:0] MsbFlip = (OFFSET_BIN != 0) ? (DAC_W'(1) << (DAC_W - 1)) : '0;

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} spi_state_e;

    logic                  rst_out_q, rst_out_d;
    logic [RstW-1:0]       rst_cnt_q, rst_cnt_d;
    spi_state_e            state_q, state_d;
    logic [DivW-1:0]       div_q, div_d;
    logic [3:0]            bit_q, bit_d;
    logic                  sck_q, sck_d;
    logic                  scs_q, scs_d;
    logic [15:0]           shreg_q, shreg_d;
    logic                  rw_q, rw_d;
    logic [7:0]            rx_q, rx_d;
    logic [7:0]            rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic [N_CH*DAC_W-1:0] in_q, in_d;
    logic [N_CH*DAC_W-1:0] shadow_q, shadow_d;
    logic [ChW-1:0]        ch_q, ch_d;
    logic [DAC_W-1:0]      dout_q, dout_d;
    logic                  dci_q, dci_d;
    logic                  div_last;

    always_comb begin
        rst_cnt_d = rst_cnt_q;
        rst_out_d = rst_out_q;
        if (rst_out_q) begin
            rst_cnt_d = rst_cnt_q + 1'b1;
            if (rst_cnt_q == RstLast) begin
                rst_out_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sck_d    = sck_q;
        scs_d    = scs_q;
        shreg_d  = shreg_q;
        rw_d     = rw_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        div_last = (div_q == DivLast);
        unique case (state_q)
            StIdle: begin
                if (cmd_trig_in && !rst_out_q) begin
                    state_d = StSetup;
                    scs_d   = 1'b0;
                    div_d   = '0;
                    rw_d    = cmd_rw_in;
                    shreg_d = {cmd_rw_in, 2'b00, cmd_addr_in, cmd_rw_in ? 8'h00 : cmd_data_in};
                end
            end
            StSetup: begin
                if (div_last) begin
                    state_d = StShift;
                    div_d   = '0;
                    bit_d   = 4'd15;
                    sck_d   = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShift: begin
                if (div_last) begin
                    div_d = '0;
                    if (sck_q) begin
                        sck_d   = 1'b0;
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end else if (bit_q == 4'd0) begin
                        state_d = StHold;
                    end else begin
                        // Rising edge of bit (bit_q-1); read data occupies bits 7..0
                        sck_d = 1'b1;
                        bit_d = bit_q - 1'b1;
                        if (rw_q && bit_q <= 4'd8) begin
                            rx_d = {rx_q[6:0], spi_sdi_in};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StHold: begin
                if (div_last) begin
                    state_d = StIdle;
                    scs_d   = 1'b1;
                    done_d  = 1'b1;
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // New dac_in wins over the held value when valid coincides with the frame copy
    always_comb begin
        in_d     = dac_valid_in ? dac_in : in_q;
        shadow_d = (ch_q == ChLast) ? in_d : shadow_q;
        ch_d     = (ch_q == ChLast) ? '0 : ch_q + 1'b1;
        dout_d   = shadow_q[int'(ch_q)*DAC_W +: DAC_W] ^ MsbFlip;
        dci_d    = (ch_q == '0);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rst_out_q <= 1'b1;
            rst_cnt_q <= '0;
            state_q   <= StIdle;
            div_q     <= '0;
            bit_q     <= '0;
            sck_q     <= 1'b0;
            scs_q     <= 1'b1;
            shreg_q   <= '0;
            rw_q      <= 1'b0;
            rx_q      <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            in_q      <= '0;
            shadow_q  <= '0;
            ch_q      <= '0;
            dout_q    <= '0;
            dci_q     <= 1'b0;
        end else begin
            rst_out_q <= rst_out_d;
            rst_cnt_q <= rst_cnt_d;
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sck_q     <= sck_d;
            scs_q     <= scs_d;
            shreg_q   <= shreg_d;
            rw_q      <= rw_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            in_q      <= in_d;
            shadow_q  <= shadow_d;
            ch_q      <= ch_d;
            dout_q    <= dout_d;
            dci_q     <= dci_d;
        end
    end

    assign rst_out      = rst_out_q;
    assign cmd_busy_out = (state_q != StIdle) || rst_out_q;
    assign cmd_done_out = done_q;
    assign cmd_data_out = rdata_q;
    assign spi_scs_out  = scs_q;
    assign spi_sck_out  = sck_q;
    assign spi_sdo_out  = shreg_q[15];
    assign d_out        = dout_q;
    assign dci_out      = dci_q;

endmodule

// File: tb/tb_ad978x_dac_ctrl.sv
// Bench for ad978x_dac_ctrl: a 2-channel SPI-exercised instance and a 4-channel offset-binary
// instance share one sample stream, checked against a timestamp-based frame model.
module tb_ad978x_dac_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_trig = 1'b0, a_rw = 1'b0, a_sdi = 1'b0;
    logic [4:0]  a_addr = '0;
    logic [7:0]  a_wdata = '0, a_rdata;
    logic        a_busy, a_done, a_rst_out, a_scs, a_sck, a_sdo, a_dci;
    logic [15:0] a_dout;
    logic [63:0] dac_drv = '0;
    logic        dac_valid = 1'b0;
    logic [7:0]  b_rdata;
    logic        b_busy, b_done, b_rst_out, b_scs, b_sck, b_sdo, b_dci;
    logic [15:0] b_dout;

    ad978x_dac_ctrl #(
        .N_CH(2), .DAC_W(16), .SCK_DIV(4), .RST_CYCLES(64), .OFFSET_BIN(0)
    ) u_dut_a (
        .clk_in(clk), .rst_in(rst),
        .cmd_trig_in(a_trig), .cmd_rw_in(a_rw), .cmd_addr_in(a_addr), .cmd_data_in(a_wdata),
        .cmd_data_out(a_rdata), .cmd_busy_out(a_busy), .cmd_done_out(a_done),
        .rst_out(a_rst_out), .spi_scs_out(a_scs), .spi_sck_out(a_sck), .spi_sdo_out(a_sdo),
        .spi_sdi_in(a_sdi), .dac_in(dac_drv[31:0]), .dac_valid_in(dac_valid),
        .d_out(a_dout), .dci_out(a_dci)
    );

    ad978x_dac_ctrl #(
        .N_CH(4), .DAC_W(16), .SCK_DIV(1), .RST_CYCLES(5), .OFFSET_BIN(1)
    ) u_dut_b (
        .clk_in(clk), .rst_in(rst),
        .cmd_trig_in(1'b0), .cmd_rw_in(1'b0), .cmd_addr_in(5'd0), .cmd_data_in(8'd0),
        .cmd_data_out(b_rdata), .cmd_busy_out(b_busy), .cmd_done_out(b_done),
        .rst_out(b_rst_out), .spi_scs_out(b_scs), .spi_sck_out(b_sck), .spi_sdo_out(b_sdo),
        .spi_sdi_in(1'b0), .dac_in(dac_drv), .dac_valid_in(dac_valid),
        .d_out(b_dout), .dci_out(b_dci)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame model: output in cycle e carries channel e%N of the latest value loaded up to the
    // cycle just before the current frame started.
    int          e = 0;
    logic [63:0] latest = '0;
    logic [63:0] hist [8];
    logic [15:0] exp_a = '0, exp_b = '0;
    logic        exp_a_dci = 1'b0, exp_b_dci = 1'b0;

    always @(posedge clk) begin
        int cha, chb, sa, sb;
        if (rst) begin
            e = 0; latest = '0;
            exp_a = '0; exp_b = '0; exp_a_dci = 1'b0; exp_b_dci = 1'b0;
        end else begin
            if (dac_valid) latest = dac_drv;
            hist[e % 8] = latest;
            cha = e % 2; sa = e - cha;
            chb = e % 4; sb = e - chb;
            exp_a = (sa == 0) ? 16'h0 : hist[(sa - 1) % 8][cha*16 +: 16];
            exp_b = ((sb == 0) ? 16'h0 : hist[(sb - 1) % 8][chb*16 +: 16]) ^ 16'h8000;
            exp_a_dci = (cha == 0);
            exp_b_dci = (chb == 0);
            e++;
        end
    end

    always @(posedge clk) begin
        #1;
        check("a_dout", a_dout, exp_a);
        check("a_dci", a_dci, exp_a_dci);
        check("b_dout", b_dout, exp_b);
        check("b_dci", b_dci, exp_b_dci);
        check("b_spi_idle", {b_scs, b_sck, b_sdo, b_done}, 4'b1000);
        check("b_rdata", b_rdata, 0);
    end

    // SPI monitor and slave model for instance A
    logic       prev_scs = 1'b1, prev_sck = 1'b0;
    logic       prev_at_done = 1'b0, scs_at_done = 1'b0;
    int         rises = 0, scs_low = 0, done_cnt = 0, done_total = 0, scs_low_total = 0;
    logic [15:0] frame = '0;
    logic [7:0] data_at_done = '0;
    logic [7:0] rd_byte = '0;

    always @(posedge clk) begin
        #1;
        if (!a_scs && prev_scs) begin
            rises = 0; frame = '0; scs_low = 0; done_cnt = 0;
        end
        if (!a_scs) begin
            scs_low++; scs_low_total++;
        end
        if (a_sck && !prev_sck) begin
            rises++;
            frame = {frame[14:0], a_sdo};
        end
        if (a_done) begin
            done_cnt++; done_total++;
            data_at_done = a_rdata; prev_at_done = prev_scs; scs_at_done = a_scs;
        end
        if (!a_sck) a_sdi = (rises >= 8 && rises < 16) ? rd_byte[15 - rises] : 1'($urandom);
        prev_scs = a_scs;
        prev_sck = a_sck;
    end

    logic       rand_dac = 1'b0;
    logic [7:0] exp_rdata = '0;

    task automatic tick();
        @(negedge clk);
        if (rand_dac) begin
            dac_valid = 1'($urandom);
            dac_drv   = {$urandom, $urandom};
        end
    endtask

    task automatic spi_xact(input logic rw, input logic [4:0] addr, input logic [7:0] wd,
                            input logic [7:0] rb, input bit dup);
        logic [15:0] exp_frame;
        int k;
        k = 0;
        while (a_busy && k < 1000) begin tick(); k++; end
        check("idle_wait", a_busy, 0);
        rd_byte = rb;
        tick();
        a_rw = rw; a_addr = addr; a_wdata = wd; a_trig = 1'b1;
        tick();
        a_trig = 1'b0; a_rw = 1'($urandom); a_addr = 5'($urandom); a_wdata = 8'($urandom);
        exp_frame = {rw, 2'b00, addr, rw ? 8'h00 : wd};
        k = 0;
        while (done_cnt == 0 && k < 400) begin
            tick(); k++;
            a_trig = (dup && k == 30);
        end
        a_trig = 1'b0;
        check("xact_timeout", k < 400, 1);
        repeat (3) tick();
        check("sdo_frame", frame, exp_frame);
        check("sck_rises", rises, 16);
        check("scs_low", scs_low, 34 * 4);
        check("done_count", done_cnt, 1);
        check("done_after_scs", {prev_at_done, scs_at_done}, 2'b01);
        if (rw) exp_rdata = rb;
        check("rdata_at_done", data_at_done, exp_rdata);
        check("rdata_after", a_rdata, exp_rdata);
        check("busy_after", a_busy, 0);
    endtask

    task automatic wait_rst_release(input string tag);
        int rk;
        rk = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (k <= 8) check({tag, "_b_rst"}, {b_rst_out, b_busy}, (k < 5) ? 2'b11 : 2'b00);
            if (k == 20) a_trig = 1'b0;
            if (k < 64) check({tag, "_busy"}, a_busy, 1);
            if (!a_rst_out) begin rk = k; break; end
        end
        check({tag, "_len"}, rk, 64);
        check({tag, "_busy_clr"}, a_busy, 0);
    endtask

    logic [15:0] exp6 [7] = '{16'hA222, 16'hB333, 16'hC444, 16'h8123, 16'hC567, 16'h09AB,
                              16'h4DEF};

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {a_rst_out, a_scs, a_sck, a_sdo, a_busy, a_done}, 6'b110010);
        check("rst_rdata", a_rdata, 0);
        check("rst_dout", {a_dout, a_dci, b_dout, b_dci}, 0);

        // Release reset with a trigger held during the rst_out window
        rst = 1'b0;
        a_trig = 1'b1;
        wait_rst_release("rst1");
        check("no_scs_in_rst", scs_low_total, 0);

        // Two-channel alternation, offset binary on the 4-channel instance
        @(negedge clk); dac_drv = 64'h5555_AAAA_5555_AAAA; dac_valid = 1'b1;
        @(negedge clk); dac_valid = 1'b0; dac_drv = {$urandom, $urandom};
        repeat (8) @(negedge clk);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!b_dci && k < 8);
        for (int i = 0; i < 8; i++) begin
            check("mux_a", {a_dout, a_dci}, (i % 2 == 0) ? {16'hAAAA, 1'b1} : {16'h5555, 1'b0});
            check("mux_b", {b_dout, b_dci},
                  (i % 2 == 0) ? {16'h2AAA, i % 4 == 0} : {16'hD555, 1'b0});
            @(posedge clk); #1;
        end

        // Four-channel mid-frame update must not tear the frame in progress
        @(negedge clk); dac_drv = 64'h4444_3333_2222_1111; dac_valid = 1'b1;
        @(negedge clk); dac_valid = 1'b0;
        repeat (10) @(negedge clk);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!b_dci && k < 8);
        check("frame6_align", b_dout, 16'h9111);
        @(negedge clk); dac_drv = 64'hCDEF_89AB_4567_0123; dac_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            check("frame6", b_dout, exp6[i]);
            @(negedge clk); dac_valid = 1'b0; dac_drv = {$urandom, $urandom};
        end

        spi_xact(1'b0, 5'h02, 8'hA5, 8'h96, 1'b0);
        spi_xact(1'b1, 5'h1F, 8'hFF, 8'h3C, 1'b0);
        spi_xact(1'b0, 5'h0B, 8'h5A, 8'hC3, 1'b1);

        // Abort mid-SHIFT
        tick();
        a_rw = 1'b0; a_addr = 5'h05; a_wdata = 8'h77; a_trig = 1'b1;
        tick();
        a_trig = 1'b0;
        repeat (40) tick();
        k = done_total;
        check("abort_pre_scs", a_scs, 0);
        rst = 1'b1;
        #1;
        check("abort_state", {a_scs, a_sck, a_sdo, a_rst_out, a_busy, a_done}, 6'b100110);
        check("abort_rdata", a_rdata, 0);
        exp_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_rst_release("rst2");
        check("abort_no_done", done_total, k);

        rand_dac = 1'b1;
        for (int i = 0; i < 12; i++) begin
            spi_xact(1'($urandom), 5'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        rand_dac = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/ad978x_dac_ctrl.md
Name: ad978x_dac_ctrl

Overview:
- Parametrised successor to the AD9783 driver, for the same SuperLaserLand DAC boards.
- Combines three functions: an SPI register master with write and read-back, a timed DAC hardware reset, and an N-channel sample multiplexer with a frame-marker DCI.
- Sits between the servo/command fabric and the output LVDS buffers. The buffers and any DDR primitives are instantiated outside this block.

Parameters:
N_CH, 2, number of DAC channels multiplexed onto d_out (2..8)
DAC_W, 16, DAC sample width in bits
SCK_DIV, 4, SPI SCK half-period in clk_in cycles (>=1)
RST_CYCLES, 64, clk_in cycles rst_out is held high after rst_in deasserts
OFFSET_BIN, 0, 1 = invert the sample MSB on output (two's complement to offset binary)

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous, active-high reset
cmd_trig_in  in  1  one-cycle SPI transaction request
cmd_rw_in  in  1  1 = read, 0 = write
cmd_addr_in  in  5  DAC register address
cmd_data_in  in  8  write data
cmd_data_out  out  8  last read-back byte
cmd_busy_out  out  1  SPI engine busy, or rst_out active
cmd_done_out  out  1  one-cycle pulse at end of a transaction
rst_out  out  1  DAC hardware reset
spi_scs_out  out  1  SPI chip select, active low
spi_sck_out  out  1  SPI clock, idle low
spi_sdo_out  out  1  SPI data to DAC
spi_sdi_in  in  1  SPI data from DAC
dac_in  in  N_CH*DAC_W  packed samples; channel k occupies bits [k*DAC_W +: DAC_W]
dac_valid_in  in  1  load dac_in into the input register
d_out  out  DAC_W  multiplexed sample stream
dci_out  out  1  high while d_out carries channel 0

Behaviour:
- Reset values while rst_in is high, all applied asynchronously:
  - rst_out=1, spi_scs_out=1, spi_sck_out=0, spi_sdo_out=0
  - cmd_busy_out=1, cmd_done_out=0, cmd_data_out=0
  - d_out=0, dci_out=0
  - channel counter=0, input register=0, shadow register=0
- Reset sequencer:
  - After rst_in falls, rst_out stays high for exactly RST_CYCLES clk_in cycles, then goes to 0.
  - cmd_busy_out stays 1 until rst_out=0.
- SPI frame: 16 bits, MSB first = {rw, 2'b00, addr[4:0], data[7:0]}.
  - For reads, the data field is driven as 0.
- SPI FSM states: IDLE, SETUP, SHIFT, HOLD.
  - IDLE: cmd_trig_in is accepted only when cmd_busy_out=0; it is ignored otherwise, with no queueing. Acceptance latches rw, addr and data, sets busy, and moves to SETUP.
  - SETUP: scs=0, sdo=bit15, sck=0 for SCK_DIV cycles.
  - SHIFT: 16 bit periods.
    - Each bit period is sck high for SCK_DIV cycles, then low for SCK_DIV cycles.
    - sdo advances to the next bit on the sck falling edge.
    - When rw=1, spi_sdi_in is sampled on each sck rising edge of bits 7..0, MSB first.
  - HOLD: scs=0, sck=0 for SCK_DIV cycles. Then go to IDLE with scs=1.
- Transaction completion, on the transition into IDLE:
  - cmd_done_out pulses for one cycle.
  - busy clears.
  - If rw=1, cmd_data_out loads the captured byte. If rw=0, cmd_data_out is unchanged.
  - Timing: from the trig-accept edge, scs is low for exactly 34*SCK_DIV cycles, and done is asserted in the first cycle after scs returns high.
- rst_in asserted mid-transaction aborts immediately: scs=1, no done pulse, cmd_data_out=0.
- Sample path:
  - Input register loads dac_in on any cycle with dac_valid_in=1, and holds otherwise.
  - Channel counter ch runs 0..N_CH-1 every cycle and wraps.
  - On the cycle ch==N_CH-1, the shadow register copies the input register, giving a coherent frame.
  - Registered outputs: d_out <= shadow[ch] (MSB inverted if OFFSET_BIN=1), dci_out <= (ch==0).
  - A sample loaded with valid in cycle t appears at d_out starting with the next frame's channel 0, no earlier than t+2.
  - A simultaneous valid and shadow copy takes the new dac_in value.
- The sample path runs independently of SPI and of rst_out. It is held in reset only by rst_in.

Test Plan:
1. Reset release, RST_CYCLES=64 → rst_out falls exactly 64 cycles after rst_in falls. A trig during that window gives no scs activity.
2. Write, addr=0x02, data=0xA5, SCK_DIV=4 → sdo bitstream 0x02A5 with 16 sck rising edges. scs is low for 136 cycles. done pulses once. cmd_data_out is unchanged.
3. Read, addr=0x1F, with spi_sdi_in driven with 0x3C on the data-phase rising edges → frame header 0x9F. cmd_data_out=0x3C in the same cycle done pulses.
4. Trig asserted while busy, then rst_in asserted mid-SHIFT → the second trig is ignored. The abort forces scs=1, gives no done pulse, and cmd_data_out=0.
5. Mux, N_CH=2: DAC0=0xAAAA, DAC1=0x5555, loaded with valid → d_out alternates 0xAAAA/0x5555, with dci_out=1 on 0xAAAA. With OFFSET_BIN=1 it alternates 0x2AAA/0xD555.
6. N_CH=4: change dac_in mid-frame with valid → the frame in progress is unchanged, and the next frame carries all four new values with no mixing.
